// File: rtl/bus_arbiter_if.sv
// Shared-bus arbitration signals between the two masters, the slaves and
// the arbiter. The arbiter connects through the master modport.
interface bus_arbiter_if #(
    parameter int SLAVE_LEN = 2,
    parameter int BURST_LEN = 12
);
    localparam int NSLV = 2 ** SLAVE_LEN;

    logic                 req_m1;
    logic                 req_m2;
    logic [SLAVE_LEN-1:0] slave_sel_m1;
    logic [SLAVE_LEN-1:0] slave_sel_m2;
    logic [BURST_LEN-1:0] burst_num_m1;
    logic [BURST_LEN-1:0] burst_num_m2;
    logic [NSLV-1:0]      slave_ready;
    logic                 beat_done;

    logic                 grant_m1;
    logic                 grant_m2;
    logic [SLAVE_LEN-1:0] slave_select;
    logic                 bus_busy;
    logic                 txn_done;
    logic                 timeout_err;

    modport master (
        input  req_m1,
        input  req_m2,
        input  slave_sel_m1,
        input  slave_sel_m2,
        input  burst_num_m1,
        input  burst_num_m2,
        input  slave_ready,
        input  beat_done,
        output grant_m1,
        output grant_m2,
        output slave_select,
        output bus_busy,
        output txn_done,
        output timeout_err
    );

    modport slave (
        output req_m1,
        output req_m2,
        output slave_sel_m1,
        output slave_sel_m2,
        output burst_num_m1,
        output burst_num_m2,
        output slave_ready,
        output beat_done,
        input  grant_m1,
        input  grant_m2,
        input  slave_select,
        input  bus_busy,
        input  txn_done,
        input  timeout_err
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin two-master bus arbiter with slave-ready wait, burst tracking,
// master abort and a watchdog on both the wait and the data phase.
module bus_arbiter #(
    parameter int SLAVE_LEN = 2,
    parameter int BURST_LEN = 12,
    parameter int TIMEOUT   = 16
) (
    input logic           clk,
    input logic           reset,
    bus_arbiter_if.master bus
);
    localparam int WDOG_W = $clog2(TIMEOUT + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIM = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SLAVE,
        OWN,
        RELEASE
    } state_t;

    typedef enum logic {
        M1 = 1'b0,
        M2 = 1'b1
    } master_t;

    state_t               state;
    master_t              owner;
    master_t              last_grant;
    logic [BURST_LEN-1:0] remaining;
    logic [WDOG_W-1:0]    wdog;

    logic                 grant_m1_q;
    logic                 grant_m2_q;
    logic [SLAVE_LEN-1:0] sel_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 tout_q;

    logic                 any_req;
    logic                 pick_m2;
    logic                 owner_req;
    logic                 tgt_ready;
    logic                 wdog_exp;
    logic [BURST_LEN-1:0] burst_m1_eff;
    logic [BURST_LEN-1:0] burst_m2_eff;

    assign any_req = bus.req_m1 | bus.req_m2;

    // On a tie the master that did not own the bus last time wins.
    assign pick_m2 = bus.req_m2 &
                     (~bus.req_m1 | (last_grant == M1));

    assign owner_req = (owner == M1) ? bus.req_m1
                                     : bus.req_m2;
    assign tgt_ready = bus.slave_ready[sel_q];
    assign wdog_exp  = (wdog == WDOG_LIM);

    assign burst_m1_eff = (bus.burst_num_m1 == '0)
                        ? BURST_LEN'(1)
                        : bus.burst_num_m1;
    assign burst_m2_eff = (bus.burst_num_m2 == '0)
                        ? BURST_LEN'(1)
                        : bus.burst_num_m2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= M1;
            last_grant <= M2;
            remaining  <= '0;
            wdog       <= '0;
            grant_m1_q <= 1'b0;
            grant_m2_q <= 1'b0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tout_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            tout_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        owner  <= pick_m2 ? M2 : M1;
                        sel_q  <= pick_m2 ? bus.slave_sel_m2
                                          : bus.slave_sel_m1;
                        remaining <= pick_m2 ? burst_m2_eff
                                             : burst_m1_eff;
                        wdog   <= '0;
                        busy_q <= 1'b1;
                        state  <= WAIT_SLAVE;
                    end
                end
                WAIT_SLAVE: begin
                    if (!owner_req) begin
                        state <= RELEASE;
                    end else if (tgt_ready) begin
                        grant_m1_q <= (owner == M1);
                        grant_m2_q <= (owner == M2);
                        wdog       <= '0;
                        state      <= OWN;
                    end else if (wdog_exp) begin
                        tout_q <= 1'b1;
                        state  <= RELEASE;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                OWN: begin
                    // A dropped request wins over a same-cycle beat.
                    if (!owner_req) begin
                        grant_m1_q <= 1'b0;
                        grant_m2_q <= 1'b0;
                        state      <= RELEASE;
                    end else if (bus.beat_done) begin
                        remaining <= remaining - BURST_LEN'(1);
                        wdog      <= '0;
                        if (remaining == BURST_LEN'(1)) begin
                            done_q     <= 1'b1;
                            grant_m1_q <= 1'b0;
                            grant_m2_q <= 1'b0;
                            state      <= RELEASE;
                        end
                    end else if (wdog_exp) begin
                        tout_q     <= 1'b1;
                        grant_m1_q <= 1'b0;
                        grant_m2_q <= 1'b0;
                        state      <= RELEASE;
                    end else begin
                        wdog <= wdog + WDOG_W'(1);
                    end
                end
                RELEASE: begin
                    grant_m1_q <= 1'b0;
                    grant_m2_q <= 1'b0;
                    sel_q      <= '0;
                    busy_q     <= 1'b0;
                    wdog       <= '0;
                    remaining  <= '0;
                    last_grant <= owner;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant_m1     = grant_m1_q;
    assign bus.grant_m2     = grant_m2_q;
    assign bus.slave_select = sel_q;
    assign bus.bus_busy     = busy_q;
    assign bus.txn_done     = done_q;
    assign bus.timeout_err  = tout_q;

    a_grant_excl: assert property (
        @(posedge clk) disable iff (reset)
        !(grant_m1_q && grant_m2_q)
    );

    a_pulse_excl: assert property (
        @(posedge clk) disable iff (reset)
        !(done_q && tout_q)
    );

    a_own_remaining: assert property (
        @(posedge clk) disable iff (reset)
        (state == OWN) |-> (remaining != '0)
    );
endmodule

// File: tb/tb_bus_arbiter.sv
// Randomised scoreboard bench for bus_arbiter: planned transactions are
// predicted per bus episode and compared by an independent output monitor.
module tb_bus_arbiter;
    localparam int TIMEOUT = 16;
    localparam int K_DONE  = 0;
    localparam int K_TO    = 1;
    localparam int K_ABORT = 2;
    localparam int K_RST   = 3;

    typedef struct {
        int m;
        int s;
        int b;
        int rd;
        int aw;
        int ab_at;
        bit ab_beat;
        int gaps[8];
    } plan_t;

    typedef struct {
        int kind;
        int m;
        int s;
        int gcyc;
        int bcyc;
    } exp_t;

    logic clk;
    logic reset;

    bus_arbiter_if #(.SLAVE_LEN(2), .BURST_LEN(12)) bus ();

    bus_arbiter #(
        .SLAVE_LEN(2),
        .BURST_LEN(12),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   model_last;
    exp_t exp_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: outcome of one bus episode from the plan alone.
    function automatic exp_t predict(input plan_t p);
        exp_t e;
        int eff;
        int t;
        eff    = (p.b == 0) ? 1 : p.b;
        e.m    = p.m;
        e.s    = p.s;
        e.gcyc = 0;
        if (p.aw >= 0 && p.aw <= p.rd && p.aw < TIMEOUT) begin
            e.kind = K_ABORT;
            e.bcyc = p.aw + 2;
            return e;
        end
        if (p.rd >= TIMEOUT) begin
            e.kind = K_TO;
            e.bcyc = TIMEOUT + 1;
            return e;
        end
        t      = 0;
        e.kind = K_DONE;
        for (int k = 0; k < eff; k++) begin
            if (p.ab_at == k) begin
                t += 1;
                e.kind = K_ABORT;
                break;
            end
            if (p.gaps[k] >= TIMEOUT) begin
                t += TIMEOUT;
                e.kind = K_TO;
                break;
            end
            t += p.gaps[k] + 1;
        end
        e.gcyc = t;
        e.bcyc = p.rd + t + 2;
        return e;
    endfunction

    function automatic plan_t mk(input int m, input int s,
                                 input int b, input int rd);
        plan_t p;
        p.m       = m;
        p.s       = s;
        p.b       = b;
        p.rd      = rd;
        p.aw      = -1;
        p.ab_at   = -1;
        p.ab_beat = 1'b0;
        for (int i = 0; i < 8; i++) p.gaps[i] = 0;
        return p;
    endfunction

    function automatic plan_t rand_plan(input int m);
        plan_t p;
        int r;
        int eff;
        p = mk(m, $urandom_range(0, 3), 0, 0);
        p.b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
        r = $urandom_range(0, 9);
        if (r < 6) p.rd = $urandom_range(0, 3);
        else if (r == 6) p.rd = TIMEOUT - 1;
        else if (r == 7) p.rd = TIMEOUT;
        else p.rd = $urandom_range(4, TIMEOUT + 3);
        if ($urandom_range(0, 7) == 0)
            p.aw = $urandom_range(0, TIMEOUT - 1);
        eff = (p.b == 0) ? 1 : p.b;
        if ($urandom_range(0, 5) == 0)
            p.ab_at = $urandom_range(0, eff - 1);
        p.ab_beat = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) begin
            r = $urandom_range(0, 19);
            if (r < 17) p.gaps[i] = $urandom_range(0, 2);
            else if (r == 17) p.gaps[i] = TIMEOUT - 1;
            else if (r == 18) p.gaps[i] = TIMEOUT;
            else p.gaps[i] = TIMEOUT + 1;
        end
        return p;
    endfunction

    task automatic set_req(input int m, input logic v);
        if (m == 1) bus.req_m1 = v;
        else bus.req_m2 = v;
    endtask

    task automatic apply_cmd(input plan_t p);
        if (p.m == 1) begin
            bus.slave_sel_m1 = 2'(p.s);
            bus.burst_num_m1 = 12'(p.b);
        end else begin
            bus.slave_sel_m2 = 2'(p.s);
            bus.burst_num_m2 = 12'(p.b);
        end
    endtask

    // Other slaves' ready lines toggle randomly; only bit s is planned.
    task automatic set_ready(input int s, input logic v);
        logic [3:0] n;
        n = 4'($urandom);
        n[s] = v;
        bus.slave_ready = n;
    endtask

    // Entered at the negedge just before the IDLE edge that sees the req.
    task automatic run_episode(input plan_t p);
        int eff;
        eff = (p.b == 0) ? 1 : p.b;
        @(negedge clk);
        for (int x = 0; x < 1000; x++) begin
            set_ready(p.s, logic'(x == p.rd));
            bus.beat_done = 1'($urandom_range(0, 1));
            if (p.aw == x) begin
                set_req(p.m, 1'b0);
                @(negedge clk);
                set_ready(p.s, 1'b0);
                return;
            end
            if (p.rd == x) begin
                @(negedge clk);
                set_ready(p.s, 1'b0);
                break;
            end
            if (x == TIMEOUT - 1) begin
                @(negedge clk);
                set_req(p.m, 1'b0);
                return;
            end
            @(negedge clk);
        end
        bus.beat_done = 1'b0;
        for (int k = 0; k < eff; k++) begin
            if (p.ab_at == k) begin
                set_req(p.m, 1'b0);
                bus.beat_done = p.ab_beat;
                @(negedge clk);
                bus.beat_done = 1'b0;
                return;
            end
            if (p.gaps[k] >= TIMEOUT) begin
                repeat (TIMEOUT) @(negedge clk);
                set_req(p.m, 1'b0);
                return;
            end
            repeat (p.gaps[k]) @(negedge clk);
            bus.beat_done = 1'b1;
            @(negedge clk);
            bus.beat_done = 1'b0;
        end
        set_req(p.m, 1'b0);
    endtask

    task automatic idle_gap();
        repeat (1 + $urandom_range(0, 2)) begin
            @(negedge clk);
            bus.beat_done   = 1'($urandom_range(0, 1));
            bus.slave_ready = 4'($urandom);
        end
    endtask

    // a must target master 1 and b master 2 when both request together.
    task automatic scenario(input plan_t a, input plan_t b,
                            input bit both);
        plan_t w;
        plan_t l;
        idle_gap();
        if (!both) begin
            apply_cmd(a);
            exp_q.push_back(predict(a));
            model_last = a.m;
            set_req(a.m, 1'b1);
            run_episode(a);
        end else begin
            if (model_last == 2) begin
                w = a;
                l = b;
            end else begin
                w = b;
                l = a;
            end
            apply_cmd(a);
            apply_cmd(b);
            exp_q.push_back(predict(w));
            exp_q.push_back(predict(l));
            set_req(1, 1'b1);
            set_req(2, 1'b1);
            run_episode(w);
            @(negedge clk);
            run_episode(l);
            model_last = l.m;
        end
    endtask

    task automatic reset_mid_own();
        exp_t e;
        idle_gap();
        apply_cmd(mk(1, 3, 5, 0));
        e.kind = K_RST;
        e.m    = 1;
        e.s    = 3;
        e.gcyc = 3;
        e.bcyc = 4;
        exp_q.push_back(e);
        set_req(1, 1'b1);
        @(negedge clk);
        set_ready(3, 1'b1);
        bus.beat_done = 1'b0;
        @(negedge clk);
        set_ready(3, 1'b0);
        bus.beat_done = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.beat_done = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_req(1, 1'b0);
        model_last = 2;
    endtask

    bit prev_g = 1'b0;
    bit in_ep  = 1'b0;
    int ep_sel;
    int ep_g;
    int ep_b;
    int ep_m;
    int ep_done;
    int ep_to;

    always @(posedge clk) begin
        exp_t e;
        bit g1;
        bit g2;
        #1;
        g1 = bus.grant_m1;
        g2 = bus.grant_m2;
        check("grant_excl", int'(g1 & g2), 0);
        if (bus.txn_done) begin
            check("done_grant_low", int'(g1 | g2), 0);
            check("done_after_grant", int'(prev_g), 1);
        end
        if (bus.timeout_err)
            check("timeout_grant_low", int'(g1 | g2), 0);
        if (!bus.bus_busy) begin
            if (in_ep) begin
                in_ep = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_episode", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_cycles", ep_g, e.gcyc);
                    check("busy_cycles", ep_b, e.bcyc);
                    check("slave_select", ep_sel, e.s);
                    check("grant_master", ep_m,
                          (e.gcyc > 0) ? e.m : 0);
                    check("txn_done_pulses", ep_done,
                          (e.kind == K_DONE) ? 1 : 0);
                    check("timeout_pulses", ep_to,
                          (e.kind == K_TO) ? 1 : 0);
                end
            end
            check("idle_outputs",
                  int'({g1, g2, bus.slave_select,
                        bus.txn_done, bus.timeout_err}), 0);
        end else begin
            if (!in_ep) begin
                in_ep   = 1'b1;
                ep_sel  = int'(bus.slave_select);
                ep_g    = 0;
                ep_b    = 0;
                ep_m    = 0;
                ep_done = 0;
                ep_to   = 0;
            end else begin
                check("sel_stable", int'(bus.slave_select), ep_sel);
            end
            ep_b    += 1;
            ep_g    += int'(g1 | g2);
            ep_m    |= (g1 ? 1 : 0) | (g2 ? 2 : 0);
            ep_done += int'(bus.txn_done);
            ep_to   += int'(bus.timeout_err);
        end
        prev_g = g1 | g2;
    end

    initial begin
        plan_t p;
        plan_t q;
        reset            = 1'b1;
        bus.req_m1       = 1'b0;
        bus.req_m2       = 1'b0;
        bus.slave_sel_m1 = '0;
        bus.slave_sel_m2 = '0;
        bus.burst_num_m1 = '0;
        bus.burst_num_m2 = '0;
        bus.slave_ready  = '0;
        bus.beat_done    = 1'b0;
        model_last       = 2;
        repeat (3) @(negedge clk);
        check("reset_state",
              int'({bus.grant_m1, bus.grant_m2, bus.slave_select,
                    bus.bus_busy, bus.txn_done, bus.timeout_err}), 0);
        reset = 1'b0;

        scenario(mk(1, 0, 1, 0), mk(2, 1, 1, 0), 1'b1);
        scenario(mk(1, 0, 1, 0), mk(2, 1, 1, 0), 1'b1);
        scenario(mk(1, 2, 3, 0), mk(2, 0, 1, 0), 1'b0);
        scenario(mk(2, 1, 1, TIMEOUT + 5), mk(2, 0, 1, 0), 1'b0);
        p = mk(1, 0, 5, 0);
        p.ab_at = 2;
        scenario(p, p, 1'b0);
        scenario(mk(1, 3, 0, 0), mk(2, 0, 1, 0), 1'b0);
        p = mk(2, 2, 2, 0);
        p.gaps[0] = TIMEOUT - 1;
        p.gaps[1] = TIMEOUT - 1;
        scenario(p, p, 1'b0);
        p = mk(2, 2, 2, 0);
        p.gaps[1] = TIMEOUT;
        scenario(p, p, 1'b0);

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                scenario(rand_plan(1), rand_plan(2), 1'b1);
            end else begin
                p = rand_plan($urandom_range(1, 2));
                scenario(p, p, 1'b0);
            end
        end

        reset_mid_own();
        scenario(mk(2, 1, 2, 1), mk(2, 1, 2, 1), 1'b0);
        reset_mid_own();
        p = rand_plan(1);
        q = rand_plan(2);
        scenario(p, q, 1'b1);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++)
            @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
